// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Define MEM_ARB_STATS_EN to add grant and conflict counters.
module mem_port_arbiter #(
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_rsp_valid_o,
    output logic [DWIDTH-1:0] if_rsp_data_o,
    output logic              if_rsp_err_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic              d_we_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rsp_data_o,
    output logic              d_rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       if_grant_cnt_o,
    output logic [31:0]       d_grant_cnt_o,
    output logic [31:0]       conflict_cnt_o,
`endif
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q;
    logic              last_d_q;
    logic              owner_d_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [3:0]        cnt_q;
    logic              if_rsp_valid_q, d_rsp_valid_q;
    logic              if_rsp_err_q, d_rsp_err_q;
    logic [DWIDTH-1:0] if_rsp_data_q, d_rsp_data_q;

    logic              grant_if, grant_d, grant_any, misaligned, in_access;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic [2:0]        sel_funct3;
    logic              sel_we;
    logic              rsp_fire, rsp_to_d, rsp_err;
    logic [DWIDTH-1:0] rsp_val;

    // Ties go to whichever port did not win last; last_d_q resets to D so IF wins first.
    always_comb begin
        grant_if   = (state_q == StIdle) && !rst && if_req_valid_i && (!d_req_valid_i || last_d_q);
        grant_d    = (state_q == StIdle) && !rst && d_req_valid_i && !grant_if;
        grant_any  = grant_if || grant_d;
        sel_addr   = grant_d ? d_addr_i : if_addr_i;
        sel_wdata  = grant_d ? d_wdata_i : '0;
        sel_funct3 = grant_d ? d_funct3_i : 3'b010;
        sel_we     = grant_d && d_we_i;
        case (sel_funct3)
            3'b010:         misaligned = |sel_addr[1:0];
            3'b001, 3'b101: misaligned = sel_addr[0];
            default:        misaligned = 1'b0;
        endcase
        in_access = (state_q == StAccess);
        rsp_fire  = (grant_any && misaligned) || (in_access && cnt_q == 4'd0);
        rsp_to_d  = (state_q == StIdle) ? grant_d : owner_d_q;
        rsp_err   = (state_q == StIdle);
        rsp_val   = ((state_q == StIdle) || we_q) ? '0 : mem_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            last_d_q       <= 1'b1;
            owner_d_q      <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            funct3_q       <= 3'b000;
            cnt_q          <= 4'd0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_err_q    <= 1'b0;
            d_rsp_data_q   <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        we_q      <= sel_we;
                        funct3_q  <= sel_funct3;
                        owner_d_q <= grant_d;
                        last_d_q  <= grant_d;
                        cnt_q     <= 4'(WAIT_CYCLES);
                        state_q   <= misaligned ? StResp : StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) state_q <= StResp;
                    else cnt_q <= cnt_q - 4'd1;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (rsp_fire) begin
                if (rsp_to_d) begin
                    d_rsp_valid_q <= 1'b1;
                    d_rsp_data_q  <= rsp_val;
                    d_rsp_err_q   <= rsp_err;
                end else begin
                    if_rsp_valid_q <= 1'b1;
                    if_rsp_data_q  <= rsp_val;
                    if_rsp_err_q   <= rsp_err;
                end
            end
        end
    end

    assign if_req_ready_o = grant_if;
    assign d_req_ready_o  = grant_d;
    assign if_rsp_valid_o = if_rsp_valid_q;
    assign if_rsp_data_o  = if_rsp_data_q;
    assign if_rsp_err_o   = if_rsp_err_q;
    assign d_rsp_valid_o  = d_rsp_valid_q;
    assign d_rsp_data_o   = d_rsp_data_q;
    assign d_rsp_err_o    = d_rsp_err_q;

    // Write strobe only in the last held cycle so each store writes exactly once.
    assign mem_addr_o     = in_access ? addr_q : '0;
    assign mem_data_o     = in_access ? wdata_q : '0;
    assign mem_funct3_o   = in_access ? funct3_q : 3'b000;
    assign mem_read_en_o  = in_access && !we_q;
    assign mem_write_en_o = in_access && we_q && (cnt_q == 4'd0);

`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt_q, d_grant_cnt_q, conflict_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_grant_cnt_q <= 32'd0;
            d_grant_cnt_q  <= 32'd0;
            conflict_cnt_q <= 32'd0;
        end else begin
            if (grant_if) if_grant_cnt_q <= if_grant_cnt_q + 32'd1;
            if (grant_d) d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
            if (state_q == StIdle && if_req_valid_i && d_req_valid_i) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign if_grant_cnt_o = if_grant_cnt_q;
    assign d_grant_cnt_o  = d_grant_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant order, response cycle, memory contents).
module tb_mem_port_arbiter;
    localparam int unsigned W = 1;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid_i = 1'b0, if_req_ready_o;
    logic [31:0] if_addr_i = '0;
    logic        if_rsp_valid_o, if_rsp_err_o;
    logic [31:0] if_rsp_data_o;
    logic        d_req_valid_i = 1'b0, d_req_ready_o;
    logic [31:0] d_addr_i = '0, d_wdata_i = '0;
    logic        d_we_i = 1'b0;
    logic [2:0]  d_funct3_i = 3'b000;
    logic        d_rsp_valid_o, d_rsp_err_o;
    logic [31:0] d_rsp_data_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        mem_read_en_o, mem_write_en_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_data_i = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] if_grant_cnt_o, d_grant_cnt_o, conflict_cnt_o;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
        .if_addr_i(if_addr_i), .if_rsp_valid_o(if_rsp_valid_o),
        .if_rsp_data_o(if_rsp_data_o), .if_rsp_err_o(if_rsp_err_o),
        .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_we_i(d_we_i),
        .d_funct3_i(d_funct3_i), .d_rsp_valid_o(d_rsp_valid_o),
        .d_rsp_data_o(d_rsp_data_o), .d_rsp_err_o(d_rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_funct3_o(mem_funct3_o),
`ifdef MEM_ARB_STATS_EN
        .if_grant_cnt_o(if_grant_cnt_o), .d_grant_cnt_o(d_grant_cnt_o),
        .conflict_cnt_o(conflict_cnt_o),
`endif
        .mem_data_i(mem_data_i)
    );

    // env_mem is the memory the DUT talks to; ref_mem is the model's own copy.
    logic [7:0] env_mem [1024];
    logic [7:0] ref_mem [1024];

    int checks = 0, failures = 0;

    bit          if_pend = 0, d_pend = 0, d_we_r = 0;
    logic [31:0] if_a = '0, d_a = '0, d_wd = '0;
    logic [2:0]  d_f3 = 3'b000;

    int          cyc = 0, free_at = 0, rsp_cyc = -1, acc_cyc = 0, last_acc_cyc = 0;
    bit          last_d = 1, acc_valid = 0, acc_we = 0, rsp_d = 0, rsp_e = 0;
    logic [31:0] acc_a = '0, acc_wd = '0, rsp_dat = '0, exp_if_dat = '0, exp_d_dat = '0;
    logic [2:0]  acc_f3 = 3'b000;
    int          n_if_gr = 0, n_d_gr = 0, n_conf = 0, n_writes = 0, n_mem_en = 0;
    int          if_rsp_seen = -1, d_rsp_seen = -1, nw0 = 0, ne0 = 0;
    logic        last_d_err = 1'b0;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] rd4(input bit from_ref, input logic [31:0] a);
        logic [9:0] i = a[9:0];
        if (from_ref) return {ref_mem[i+10'd3], ref_mem[i+10'd2], ref_mem[i+10'd1], ref_mem[i]};
        return {env_mem[i+10'd3], env_mem[i+10'd2], env_mem[i+10'd1], env_mem[i]};
    endfunction

    task automatic mem_wr(input bit to_ref, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d);
        int n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            if (to_ref) ref_mem[a[9:0] + 10'(k)] = d[8*k +: 8];
            else env_mem[a[9:0] + 10'(k)] = d[8*k +: 8];
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_if_rdy"}, if_req_ready_o, 0);
        chk({tag, "_d_rdy"}, d_req_ready_o, 0);
        chk({tag, "_if_rv"}, if_rsp_valid_o, 0);
        chk({tag, "_d_rv"}, d_rsp_valid_o, 0);
        chk({tag, "_if_rd"}, if_rsp_data_o, 0);
        chk({tag, "_d_rd"}, d_rsp_data_o, 0);
        chk({tag, "_if_err"}, if_rsp_err_o, 0);
        chk({tag, "_d_err"}, d_rsp_err_o, 0);
        chk({tag, "_maddr"}, mem_addr_o, 0);
        chk({tag, "_mdata"}, mem_data_o, 0);
        chk({tag, "_mre"}, mem_read_en_o, 0);
        chk({tag, "_mwe"}, mem_write_en_o, 0);
        chk({tag, "_mf3"}, mem_funct3_o, 0);
    endtask

    // One clock: serve memory, drive requests, then compare against the model.
    task automatic step();
        bit gi, gd, mis, in_acc, exp_iv, exp_dv;
        logic [31:0] la;
        logic [2:0] lf;
        @(negedge clk);
        if (mem_write_en_o) begin
            mem_wr(0, mem_addr_o, mem_funct3_o, mem_data_o);
            n_writes++;
        end
        if (mem_write_en_o || mem_read_en_o) n_mem_en++;
        mem_data_i = ext(mem_funct3_o, rd4(0, mem_addr_o));
        if_req_valid_i = if_pend;
        if_addr_i = if_pend ? if_a : $urandom();
        d_req_valid_i = d_pend;
        d_addr_i = d_pend ? d_a : $urandom();
        d_wdata_i = d_pend ? d_wd : $urandom();
        d_we_i = d_pend ? d_we_r : 1'($urandom());
        d_funct3_i = d_pend ? d_f3 : 3'($urandom());
        #1;
        gi = 0;
        gd = 0;
        if (cyc >= free_at) begin
            if (if_pend && d_pend) n_conf++;
            gd = d_pend && (!if_pend || !last_d);
            gi = if_pend && !gd;
        end
        chk("if_ready", if_req_ready_o, gi);
        chk("d_ready", d_req_ready_o, gd);
        if (gi || gd) begin
            la = gd ? d_a : if_a;
            lf = gd ? d_f3 : 3'b010;
            mis = (lf == 3'b010 && la[1:0] != 2'b00) || ((lf == 3'b001 || lf == 3'b101) && la[0]);
            last_d = gd;
            last_acc_cyc = cyc;
            if (gd) n_d_gr++;
            else n_if_gr++;
            rsp_d = gd;
            rsp_e = mis;
            acc_valid = !mis;
            acc_cyc = cyc;
            acc_a = la;
            acc_f3 = lf;
            acc_we = gd && d_we_r;
            acc_wd = gd ? d_wd : 32'h0;
            rsp_cyc = mis ? cyc + 1 : cyc + int'(W) + 2;
            rsp_dat = (mis || acc_we) ? 32'h0 : ext(lf, rd4(1, la));
            free_at = rsp_cyc + 1;
            if (gd) d_pend = 0;
            else if_pend = 0;
        end
        in_acc = acc_valid && cyc > acc_cyc && cyc <= acc_cyc + int'(W) + 1;
        chk("mem_addr", mem_addr_o, in_acc ? acc_a : 32'h0);
        chk("mem_data", mem_data_o, in_acc ? acc_wd : 32'h0);
        chk("mem_f3", mem_funct3_o, in_acc ? acc_f3 : 3'b000);
        chk("mem_re", mem_read_en_o, in_acc && !acc_we);
        chk("mem_we", mem_write_en_o, in_acc && acc_we && cyc == acc_cyc + int'(W) + 1);
        if (in_acc && acc_we && cyc == acc_cyc + int'(W) + 1) mem_wr(1, acc_a, acc_f3, acc_wd);
        exp_iv = (rsp_cyc == cyc) && !rsp_d;
        exp_dv = (rsp_cyc == cyc) && rsp_d;
        if (exp_iv) exp_if_dat = rsp_dat;
        if (exp_dv) exp_d_dat = rsp_dat;
        chk("if_rsp_valid", if_rsp_valid_o, exp_iv);
        chk("d_rsp_valid", d_rsp_valid_o, exp_dv);
        chk("if_rsp_data", if_rsp_data_o, exp_if_dat);
        chk("d_rsp_data", d_rsp_data_o, exp_d_dat);
        if (exp_iv) chk("if_rsp_err", if_rsp_err_o, rsp_e);
        if (exp_dv) chk("d_rsp_err", d_rsp_err_o, rsp_e);
        if (if_rsp_valid_o) if_rsp_seen = cyc;
        if (d_rsp_valid_o) begin
            d_rsp_seen = cyc;
            last_d_err = d_rsp_err_o;
        end
        cyc++;
    endtask

    task automatic drain();
        repeat (W + 4) step();
    endtask

    task automatic d_req(input logic [31:0] a, input bit we, input logic [2:0] f3,
                         input logic [31:0] wd);
        d_pend = 1;
        d_a = a;
        d_we_r = we;
        d_f3 = f3;
        d_wd = wd;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem_wr(0, BASE, 3'b010, 32'h0050_0093);
        mem_wr(1, BASE, 3'b010, 32'h0050_0093);

        repeat (2) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;

        // Tie right after reset: IF, then D, then IF again on the next tie.
        if_pend = 1;
        if_a = BASE;
        d_req(BASE, 0, 3'b010, 32'h1111_2222);
        repeat (W + 3) step();
        step();
        if_pend = 1;
        if_a = BASE + 32'h4;
        d_req(BASE + 32'h8, 0, 3'b010, 32'h0);
        repeat (2 * (W + 3) + 2) step();
`ifdef MEM_ARB_STATS_EN
        chk("conflict_cnt_tie", conflict_cnt_o, n_conf);
`endif

        if_pend = 1;
        if_a = BASE;
        drain();
        chk("fetch_latency", if_rsp_seen - last_acc_cyc, W + 2);
        chk("fetch_data", if_rsp_data_o, 32'h0050_0093);

        nw0 = n_writes;
        d_req(BASE + 32'h100, 1, 3'b010, 32'hDEAD_BEEF);
        drain();
        chk("sw_one_write", n_writes - nw0, 1);
        d_req(BASE + 32'h100, 0, 3'b010, 32'h0);
        drain();
        chk("lw_data", d_rsp_data_o, 32'hDEAD_BEEF);

        d_req(BASE + 32'h3, 1, 3'b000, 32'h0000_0080);
        drain();
        d_req(BASE + 32'h3, 0, 3'b000, 32'h0);
        drain();
        chk("lb_data", d_rsp_data_o, 32'hFFFF_FF80);
        d_req(BASE + 32'h3, 0, 3'b100, 32'h0);
        drain();
        chk("lbu_data", d_rsp_data_o, 32'h0000_0080);

        ne0 = n_mem_en;
        d_req(BASE + 32'h101, 0, 3'b001, 32'h0);
        drain();
        chk("lh_mis_latency", d_rsp_seen - last_acc_cyc, 1);
        chk("lh_mis_err", last_d_err, 1);
        chk("lh_mis_data", d_rsp_data_o, 0);
        chk("lh_mis_no_mem", n_mem_en - ne0, 0);

        // Store aborted by reset in its first ACCESS cycle, before the write strobe.
        nw0 = n_writes;
        d_req(BASE + 32'h200, 1, 3'b010, 32'h1234_5678);
        step();
        step();
        if_req_valid_i = 1'b0;
        d_req_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1 all_zero("abort");
        @(negedge clk);
        all_zero("abort_held");
        rst = 1'b0;
        free_at = cyc;
        last_d = 1;
        acc_valid = 0;
        rsp_cyc = -1;
        exp_if_dat = '0;
        exp_d_dat = '0;
        n_if_gr = 0;
        n_d_gr = 0;
        n_conf = 0;
        drain();
        chk("abort_no_write", n_writes - nw0, 0);
        chk("abort_mem_word", rd4(0, BASE + 32'h200), 32'h0);

        for (int n = 0; n < 400; n++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if_a = BASE + (($urandom_range(0, 1) == 0) ? {$urandom_range(0, 15), 2'b00}
                                                            : 32'($urandom_range(0, 63)));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_we_r = 1'($urandom_range(0, 1));
                d_req(BASE + (($urandom_range(0, 1) == 0) ? {$urandom_range(0, 15), 2'b00}
                                                          : 32'($urandom_range(0, 63))),
                      d_we_r,
                      d_we_r ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)],
                      $urandom());
            end
            step();
        end
        if_pend = 0;
        d_pend = 0;
        repeat (2 * (W + 4)) step();
        for (int i = 0; i < 64; i += 4) begin
            chk("final_mem", rd4(0, BASE + 32'(i)), rd4(1, BASE + 32'(i)));
        end
`ifdef MEM_ARB_STATS_EN
        chk("if_grant_cnt", if_grant_cnt_o, n_if_gr);
        chk("d_grant_cnt", d_grant_cnt_o, n_d_gr);
        chk("conflict_cnt", conflict_cnt_o, n_conf);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
